// File: rtl/pwm_regbank.sv
// pwm_regbank: 12-bit control register bank for the function generator and
// the PWM engine, fed by the UART command FSM write port. Holds the FG
// configuration registers, drives the packed FG configuration bus, and runs
// a prescaled PWM timer with double-buffered period, duty and phase.
module pwm_regbank #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    input  logic [DATA_W-1:0]     fg_out_in,
    output logic [8*DATA_W-1:0]   fg_cfg,
    output logic                  pwm_out
);

    localparam logic [ADDR_W-1:0] A_FG_OUT  = 4'h8;
    localparam logic [ADDR_W-1:0] A_PWM_CLK = 4'h9;
    localparam logic [ADDR_W-1:0] A_PWM_TMR = 4'hA;
    localparam logic [ADDR_W-1:0] A_PWM_PR  = 4'hB;
    localparam logic [ADDR_W-1:0] A_PWM_DC  = 4'hC;
    localparam logic [ADDR_W-1:0] A_PWM_PH  = 4'hD;
    localparam logic [ADDR_W-1:0] A_PWM_CON = 4'hE;

    // Eight FG registers, index 0 (fg_con) lands in the low 12 bits of fg_cfg.
    logic [7:0][DATA_W-1:0] fg_reg;

    // Bank copies as seen by the host.
    logic [DATA_W-1:0] pwm_clk;
    logic [DATA_W-1:0] pr_bank;
    logic [DATA_W-1:0] dc_bank;
    logic [DATA_W-1:0] ph_bank;
    logic [DATA_W-1:0] pwm_con;

    // Active copies used by the engine, reloaded only at period boundaries.
    logic [DATA_W-1:0] pr_act;
    logic [DATA_W-1:0] dc_act;
    logic [DATA_W-1:0] ph_act;

    logic [DATA_W-1:0] pre;
    logic [DATA_W-1:0] tmr;

    logic              enable;
    logic              invert;
    logic              tick;
    logic              wrap;
    logic              raw;
    logic [DATA_W-1:0] rd_data;

    // Compare path intermediates, one bit wider so the phase sum cannot overflow.
    logic [DATA_W:0]   ph_eff;
    logic [DATA_W:0]   phase_sum;
    logic [DATA_W:0]   period_len;
    logic [DATA_W:0]   phase_pos;

    assign fg_cfg = fg_reg;
    assign enable = pwm_con[0];
    assign invert = pwm_con[1];
    assign tick   = (pre == pwm_clk);
    // A timer that has run past the period (reset/enable race) also wraps.
    assign wrap   = tick && (tmr >= pr_act);

    // Host writes into the RW registers; read-only and unused addresses are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fg_reg  <= '0;
            pwm_clk <= '0;
            pr_bank <= '0;
            dc_bank <= '0;
            ph_bank <= '0;
            pwm_con <= '0;
        end else if (write_en) begin
            case (addr)
                4'h0, 4'h1, 4'h2, 4'h3,
                4'h4, 4'h5, 4'h6, 4'h7: fg_reg[addr[2:0]] <= data_in;
                A_PWM_CLK:              pwm_clk <= data_in;
                A_PWM_PR:               pr_bank <= data_in;
                A_PWM_DC:               dc_bank <= data_in;
                A_PWM_PH:               ph_bank <= data_in;
                A_PWM_CON:              pwm_con <= data_in;
                default:                ;
            endcase
        end
    end

    // Prescaler and timer; active copies follow the bank while idle and latch at each wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre    <= '0;
            tmr    <= '0;
            pr_act <= '0;
            dc_act <= '0;
            ph_act <= '0;
        end else if (!enable) begin
            pre    <= '0;
            tmr    <= '0;
            pr_act <= pr_bank;
            dc_act <= dc_bank;
            ph_act <= ph_bank;
        end else if (tick) begin
            pre <= '0;
            if (wrap) begin
                tmr    <= '0;
                pr_act <= pr_bank;
                dc_act <= dc_bank;
                ph_act <= ph_bank;
            end else begin
                tmr <= tmr + 1'b1;
            end
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Phase-shifted duty compare; an out-of-range phase is treated as zero.
    always_comb begin
        ph_eff     = (ph_act > pr_act) ? '0 : {1'b0, ph_act};
        phase_sum  = {1'b0, tmr} + ph_eff;
        period_len = {1'b0, pr_act} + (DATA_W+1)'(1);
        phase_pos  = (phase_sum >= period_len) ? (phase_sum - period_len) : phase_sum;
        raw        = (phase_pos < {1'b0, dc_act});
    end

    // Registered PWM output; a disabled engine parks at the idle (inverted) level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= enable ? (raw ^ invert) : invert;
        end
    end

    // Read source select for the addressed register.
    always_comb begin
        rd_data = '0;
        case (addr)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7: rd_data = fg_reg[addr[2:0]];
            A_FG_OUT:               rd_data = fg_out_in;
            A_PWM_CLK:              rd_data = pwm_clk;
            A_PWM_TMR:              rd_data = tmr;
            A_PWM_PR:               rd_data = pr_bank;
            A_PWM_DC:               rd_data = dc_bank;
            A_PWM_PH:               rd_data = ph_bank;
            A_PWM_CON:              rd_data = pwm_con;
            default:                rd_data = '0;
        endcase
    end

    // Read data is registered every cycle regardless of write activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_pwm_regbank.sv
// tb_pwm_regbank: directed scoreboard bench for pwm_regbank. Stimulus pushes
// expected values tagged with the cycle they are due; a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_pwm_regbank;

    localparam int S_DOUT = 0;
    localparam int S_PWM  = 1;
    localparam int S_FG   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic [3:0]  addr;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic [11:0] fg_out_in;
    logic [95:0] fg_cfg;
    logic        pwm_out;

    typedef struct {
        int          due;
        int          sig;
        logic [95:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    pwm_regbank dut (
        .clk       (clk),
        .reset     (reset),
        .write_en  (write_en),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .fg_out_in (fg_out_in),
        .fg_cfg    (fg_cfg),
        .pwm_out   (pwm_out)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Rising-edge counter used to time-stamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the bench can never hang.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: on each falling edge compare every expectation due now.
    initial begin
        logic [95:0] act;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    case (sb[i].sig)
                        S_DOUT:  act = {84'b0, data_out};
                        S_PWM:   act = {95'b0, pwm_out};
                        default: act = fg_cfg;
                    endcase
                    checks++;
                    if (act !== sb[i].exp) begin
                        failures++;
                        $display("[TB] FAIL %s cycle %0d: got %h, want %h",
                                 sb[i].name, cyc, act, sb[i].exp);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    // Drive one cycle of inputs at a falling edge and wait for the next one.
    task automatic applyStimulus(input logic we, input logic [3:0] a, input logic [11:0] d);
        write_en = we;
        addr     = a;
        data_in  = d;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    // Queue an expectation due 'offset' rising edges from now.
    task automatic checkOutput(input int sig, input int offset, input logic [95:0] exp,
                               input string name);
        chk_t c;
        c.due  = cyc + offset;
        c.sig  = sig;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    // Timer value m cycles after the enabling edge.
    function automatic int tmr_ref(int m, int ck, int pr);
        return (m / (ck + 1)) % (pr + 1);
    endfunction

    // Expected pwm_out for a timer sample taken m cycles after enabling.
    function automatic logic pwm_ref(int m, int ck, int pr, int dc, int ph, logic inv);
        int t;
        int s;
        t = tmr_ref(m, ck, pr);
        s = (t + ph) % (pr + 1);
        return (s < dc) ^ inv;
    endfunction

    // Disable the engine and load a fresh configuration.
    task automatic pwm_cfg(input int ck, input int pr, input int dc, input int ph);
        applyStimulus(1'b1, 4'hE, 12'h000);
        applyStimulus(1'b1, 4'h9, 12'(ck));
        applyStimulus(1'b1, 4'hB, 12'(pr));
        applyStimulus(1'b1, 4'hC, 12'(dc));
        applyStimulus(1'b1, 4'hD, 12'(ph));
    endtask

    // Enable with 'con' and expect n cycles of pwm_out and live timer reads.
    task automatic pwm_run(input int con, input int ck, input int pr, input int dc,
                           input int ph, input int n, input string tag);
        for (int j = 1; j <= n; j++) begin
            checkOutput(S_PWM, 1 + j, 96'(pwm_ref(j - 1, ck, pr, dc, ph, con[1])),
                        {tag, "_pwm"});
            checkOutput(S_DOUT, 1 + j, 96'(tmr_ref(j - 1, ck, pr)), {tag, "_tmr"});
        end
        applyStimulus(1'b1, 4'hE, 12'(con));
        repeat (n) applyStimulus(1'b0, 4'hA, 12'h000);
    endtask

    initial begin
        logic [95:0] fg_exp;
        reset     = 1'b1;
        write_en  = 1'b0;
        addr      = 4'h8;
        data_in   = '0;
        fg_out_in = 12'h123;
        repeat (3) @(negedge clk);

        // Outputs held at zero while reset is asserted, even for the 0x8 read.
        checkOutput(S_DOUT, 1, 96'h0, "dout_in_reset");
        checkOutput(S_PWM,  1, 96'h0, "pwm_in_reset");
        checkOutput(S_FG,   1, 96'h0, "fg_in_reset");
        applyStimulus(1'b0, 4'h8, 12'h000);
        reset = 1'b0;

        // Reset read sweep of the whole map.
        for (int a = 0; a < 16; a++) begin
            checkOutput(S_DOUT, 1, (a == 8) ? 96'h123 : 96'h0, "rd_after_reset");
            applyStimulus(1'b0, 4'(a), 12'h000);
        end
        checkOutput(S_FG,  1, 96'h0, "fg_after_reset");
        checkOutput(S_PWM, 1, 96'h0, "pwm_after_reset");
        applyStimulus(1'b0, 4'h0, 12'h000);

        // Single FG write, bus visible after the edge, read-back one edge later.
        checkOutput(S_FG,   1, 96'h5A3 << 48, "fg_amp_bus");
        checkOutput(S_DOUT, 1, 96'h0, "rd_during_wr");
        applyStimulus(1'b1, 4'h4, 12'h5A3);
        checkOutput(S_DOUT, 1, 96'h5A3, "rd_fg_amp");
        applyStimulus(1'b0, 4'h4, 12'h000);
        applyStimulus(1'b1, 4'h8, 12'h777);
        applyStimulus(1'b1, 4'hF, 12'h777);
        checkOutput(S_DOUT, 1, 96'h123, "rd_fg_out_ro");
        applyStimulus(1'b0, 4'h8, 12'h000);
        checkOutput(S_DOUT, 1, 96'h0, "rd_unused");
        checkOutput(S_FG,   1, 96'h5A3 << 48, "fg_bus_after_ro");
        applyStimulus(1'b0, 4'hF, 12'h000);

        // All eight FG registers with distinct values.
        fg_exp = '0;
        for (int i = 0; i < 8; i++) begin
            fg_exp[i*12 +: 12] = 12'(12'h111 * (i + 1));
            applyStimulus(1'b1, 4'(i), 12'(12'h111 * (i + 1)));
        end
        checkOutput(S_FG, 1, fg_exp, "fg_bus_all");
        applyStimulus(1'b0, 4'h0, 12'h000);
        for (int i = 0; i < 8; i++) begin
            checkOutput(S_DOUT, 1, 96'(12'h111 * (i + 1)), "rd_fg_all");
            applyStimulus(1'b0, 4'(i), 12'h000);
        end

        // Basic PWM: period 10, 3 high, with bank read-back.
        pwm_cfg(0, 9, 3, 0);
        checkOutput(S_DOUT, 1, 96'h0, "rd_pwm_clk");
        applyStimulus(1'b0, 4'h9, 12'h000);
        checkOutput(S_DOUT, 1, 96'h9, "rd_pwm_pr");
        applyStimulus(1'b0, 4'hB, 12'h000);
        checkOutput(S_DOUT, 1, 96'h3, "rd_pwm_dc");
        applyStimulus(1'b0, 4'hC, 12'h000);
        checkOutput(S_DOUT, 1, 96'h0, "rd_pwm_ph");
        applyStimulus(1'b0, 4'hD, 12'h000);
        pwm_run(1, 0, 9, 3, 0, 30, "basic");
        checkOutput(S_DOUT, 1, 96'h1, "rd_pwm_con");
        applyStimulus(1'b0, 4'hE, 12'h000);

        // Inverted output.
        pwm_cfg(0, 9, 3, 0);
        pwm_run(3, 0, 9, 3, 0, 30, "invert");

        // Prescaler of 2: period 20, 6 high.
        pwm_cfg(1, 9, 3, 0);
        pwm_run(1, 1, 9, 3, 0, 40, "presc");

        // Phase 2: high while tmr is 8, 9, 0.
        pwm_cfg(0, 9, 3, 2);
        pwm_run(1, 0, 9, 3, 2, 30, "phase");

        // Duty change mid-period, then a duty write on the wrap edge itself.
        pwm_cfg(0, 9, 3, 0);
        for (int j = 1; j <= 40; j++) begin
            checkOutput(S_PWM, 1 + j,
                        96'(pwm_ref(j - 1, 0, 9, (j <= 10) ? 3 : ((j <= 30) ? 7 : 5), 0, 1'b0)),
                        "dc_buffer_pwm");
        end
        applyStimulus(1'b1, 4'hE, 12'h001);
        repeat (4) applyStimulus(1'b0, 4'hA, 12'h000);
        applyStimulus(1'b1, 4'hC, 12'h007);
        checkOutput(S_DOUT, 1, 96'h7, "rd_dc_bank_now");
        applyStimulus(1'b0, 4'hC, 12'h000);
        repeat (13) applyStimulus(1'b0, 4'hA, 12'h000);
        applyStimulus(1'b1, 4'hC, 12'h005);
        repeat (20) applyStimulus(1'b0, 4'hA, 12'h000);

        // Duty extremes.
        pwm_cfg(0, 9, 15, 0);
        pwm_run(1, 0, 9, 15, 0, 15, "dc_high");
        pwm_cfg(0, 9, 0, 0);
        pwm_run(1, 0, 9, 0, 0, 15, "dc_low");

        // Asynchronous reset while pwm_out is high.
        pwm_cfg(0, 9, 3, 0);
        checkOutput(S_PWM, 2, 96'h1, "pwm_pre_reset");
        applyStimulus(1'b1, 4'hE, 12'h001);
        checkOutput(S_DOUT, 1, 96'h555, "dout_pre_reset");
        applyStimulus(1'b0, 4'h4, 12'h000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput(S_PWM,  0, 96'h0, "pwm_async_reset");
        checkOutput(S_DOUT, 0, 96'h0, "dout_async_reset");
        checkOutput(S_FG,   0, 96'h0, "fg_async_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checkOutput(S_PWM,  1, 96'h0, "pwm_after_rst");
            checkOutput(S_DOUT, 1, 96'h0, "con_after_rst");
            applyStimulus(1'b0, 4'hE, 12'h000);
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
            failures += sb.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
